// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
// Optional build macro: IFQ_BYPASS_EN (zero-latency forwarding when the queue is empty).
package if_id_queue_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 4;
    localparam int INSTR_W           = 32;
    localparam int PC_W              = 32;

    // One fetched instruction with its PC; also used by the IF/ID register and ID stage.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instruction;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [PC_W-1:0] pc,
                                                input logic [INSTR_W-1:0] instruction);
        fetch_entry_t e;
        e.pc          = pc;
        e.instruction = instruction;
        return e;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake bundle between IF (producer), ID (consumer), EXE flush and the queue.
// Optional build macro affecting the queue: IFQ_BYPASS_EN.
interface if_id_queue_if #(parameter int AW = 2);

    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instruction;
    logic          in_ready;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instruction;
    logic [AW:0]   count;

    // Pipeline side: drives fetch data, flush and consume; observes queue state.
    modport master (
        output in_valid, in_pc, in_instruction, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instruction, count
    );

    // Queue side.
    modport slave (
        input  in_valid, in_pc, in_instruction, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instruction, count
    );

endinterface

// File: rtl/if_id_queue_storage.sv
// Entry storage for the IF/ID queue: DEPTH registers, synchronous write, asynchronous read.
// Optional build macro affecting the queue: IFQ_BYPASS_EN (not used here).
module ifq_storage
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetch_entry_t  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetch_entry_t  o_rdata
);

    fetch_entry_t w_entries [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t r_entry;

            // Capture the incoming entry when this slot is the write target.
            always_ff @(posedge clk) begin
                if (i_we && (i_waddr == AW'(gi))) begin
                    r_entry <= i_wdata;
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    // Head read is combinational so the queue output tracks rd_ptr immediately.
    assign o_rdata = w_entries[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: in-order {pc, instruction} FIFO with flush on taken branch.
// Optional build macro: IFQ_BYPASS_EN forwards in_* to out_* when empty (0-cycle latency).
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic          w_bypass;
    logic          w_bypass_take;
    logic          w_out_valid;
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head_entry;
    fetch_entry_t  w_out_entry;

    assign w_wr_entry = make_entry(bus.in_pc, bus.in_instruction);

    ifq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head_entry)
    );

    // Handshake decode; flush cancels both sides, full/empty come from count alone.
    always_comb begin
        w_full        = (r_count == FULL_COUNT);
        w_empty       = (r_count == '0);
`ifdef IFQ_BYPASS_EN
        w_bypass      = w_empty & bus.in_valid & ~bus.flush;
        w_bypass_take = w_bypass & bus.out_ready;
`else
        w_bypass      = 1'b0;
        w_bypass_take = 1'b0;
`endif
        // A bypassed entry consumed the same cycle is never written.
        w_enq         = bus.in_valid & ~w_full & ~bus.flush & ~w_bypass_take;
        w_deq         = ~w_empty & bus.out_ready & ~bus.flush;
    end

    // Output mux: forwarded input when bypassing, else the head entry, else zeros.
    always_comb begin
        w_out_valid = 1'b0;
        w_out_entry = '0;
        if (w_bypass) begin
            w_out_valid = 1'b1;
            w_out_entry = w_wr_entry;
        end else if (!w_empty) begin
            w_out_valid = 1'b1;
            w_out_entry = w_head_entry;
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready        = ~w_full;
    assign bus.out_valid       = w_out_valid;
    assign bus.out_pc          = w_out_entry.pc;
    assign bus.out_instruction = w_out_entry.instruction;
    assign bus.count           = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed testbench for if_id_queue (DEPTH=4); expectations adapt to IFQ_BYPASS_EN.
module tb_if_id_queue;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    if_id_queue_if #(.AW(2)) ifc ();

    if_id_queue #(.DEPTH(4), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        ifc.in_valid       = v;
        ifc.in_pc          = pc;
        ifc.in_instruction = 32'hE3A0_0000 + pc;
        ifc.out_ready      = rdy;
        ifc.flush          = fl;
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, 32'(ifc.out_valid), 32'd1);
        check({tag, ".pc"}, ifc.out_pc, pc);
        check({tag, ".instr"}, ifc.out_instruction, 32'hE3A0_0000 + pc);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);

        // Reset then idle.
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst.count", 32'(ifc.count), 32'd0);
        check("rst.out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst.in_ready", 32'(ifc.in_ready), 32'd1);
        check("rst.out_pc", ifc.out_pc, 32'd0);
        check("rst.out_instr", ifc.out_instruction, 32'd0);

        // Fill to full with the consumer stalled.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0);
            tick();
            check($sformatf("fill%0d.count", i), 32'(ifc.count), 32'(i));
            check_head($sformatf("fill%0d.head", i), 32'd1);
        end
        check("full.in_ready", 32'(ifc.in_ready), 32'd0);
        drive(1'b1, 32'd5, 1'b0, 1'b0);
        tick();
        check("full.drop.count", 32'(ifc.count), 32'd4);
        check_head("full.drop.head", 32'd1);

        // Both active at full: only the dequeue happens.
        drive(1'b1, 32'd6, 1'b1, 1'b0);
        tick();
        check("fulldeq.count", 32'(ifc.count), 32'd3);
        check("fulldeq.in_ready", 32'(ifc.in_ready), 32'd1);
        check_head("fulldeq.head", 32'd2);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        check("deq.count", 32'(ifc.count), 32'd2);
        check_head("deq.head", 32'd3);
        // At count 2 with both active: count holds, order preserved.
        drive(1'b1, 32'd7, 1'b1, 1'b0);
        tick();
        check("both.count", 32'(ifc.count), 32'd2);
        check_head("both.head", 32'd4);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        check("drain1.count", 32'(ifc.count), 32'd1);
        check_head("drain1.head", 32'd7);
        tick();
        check("drain2.count", 32'(ifc.count), 32'd0);
        check("drain2.out_valid", 32'(ifc.out_valid), 32'd0);
        check("drain2.out_pc", ifc.out_pc, 32'd0);

        // Streaming: produce and consume every cycle, pointers wrap.
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'(k), 1'b1, 1'b0);
`ifdef IFQ_BYPASS_EN
            check($sformatf("stream%0d.count", k), 32'(ifc.count), 32'd0);
            check_head($sformatf("stream%0d.head", k), 32'(k));
`else
            if (k == 1) begin
                check("stream1.count", 32'(ifc.count), 32'd0);
                check("stream1.out_valid", 32'(ifc.out_valid), 32'd0);
            end else begin
                check($sformatf("stream%0d.count", k), 32'(ifc.count), 32'd1);
                check_head($sformatf("stream%0d.head", k), 32'(k - 1));
            end
`endif
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
`ifdef IFQ_BYPASS_EN
        check("streamend.count", 32'(ifc.count), 32'd0);
`else
        check("streamend.count", 32'(ifc.count), 32'd1);
        check_head("streamend.head", 32'd10);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        check("streamdrain.count", 32'(ifc.count), 32'd0);
`endif

        // Flush with three queued entries plus a wrong-path fetch in the same cycle.
        for (int i = 11; i <= 13; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0);
            tick();
        end
        check("preflush.count", 32'(ifc.count), 32'd3);
        drive(1'b1, 32'd8, 1'b0, 1'b1);
        check("flush.in_ready", 32'(ifc.in_ready), 32'd1);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("flush.count", 32'(ifc.count), 32'd0);
        check("flush.out_valid", 32'(ifc.out_valid), 32'd0);
        drive(1'b1, 32'd20, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("postflush.count", 32'(ifc.count), 32'd1);
        check_head("postflush.head", 32'd20);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        check("postflush.empty", 32'(ifc.out_valid), 32'd0);
        check("postflush.count0", 32'(ifc.count), 32'd0);

        // Reset in mid-operation drops everything.
        for (int i = 30; i <= 32; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0);
            tick();
        end
        check("prerst.count", 32'(ifc.count), 32'd3);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst.count", 32'(ifc.count), 32'd0);
        check("midrst.out_valid", 32'(ifc.out_valid), 32'd0);
        check("midrst.out_pc", ifc.out_pc, 32'd0);
        drive(1'b1, 32'd40, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        check("postrst.count", 32'(ifc.count), 32'd1);
        check_head("postrst.head", 32'd40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
